rv32im_ctrl_pipe: RTL and testbench
===================================

RV32IM_CTRL_PIPE -- requirements
Module: rv32im_ctrl_pipe

Interface
REQ-001 SHALL provide parameter ALUOP_W, default 5, width of ALUOP.
REQ-002 SHALL provide parameter ENABLE_M, default 1; when 0, the M extension (func7=0000001, opcode 0110011) is illegal.
REQ-003 SHALL provide parameter MUL_LAT, default 1, range 1..8, total EX cycles for MUL/MULH/MULHSU/MULHU.
REQ-004 SHALL provide parameter DIV_LAT, default 4, range 1..33, total EX cycles for DIV/DIVU/REM/REMU.
REQ-005 Ports, in this order:
- CLK  in  1  rising-edge clock.
- RESET  in  1  asynchronous, active-high.
- INSTRUCTION  in  32  instruction word in ID.
- IN_VALID  in  1  INSTRUCTION valid.
- FLUSH  in  1  kill the ID instruction and the registered control.
- BUSYWAIT  in  1  data memory busy.
- OUT_VALID  out  1  registered control is valid.
- DECODE_STALL  out  1  ID must hold INSTRUCTION.
- ALUOP  out  ALUOP_W  ALU operation.
- IMMflag, Jumpflag, SELECTWRITE, WRITEENABLE, READ, WRITE, ILLEGAL  out  1 each.
- LOADSIGNAL  out  3; BRANCHSIGNAL  out  3; STORESIGNAL  out  2.

Function
REQ-006 All outputs SHALL be registered on the rising edge of CLK; there SHALL be no combinational path from any input to any output.
REQ-007 The FSM SHALL have three states: RUN, MEM, MDIV.
REQ-008 In RUN with IN_VALID=1 and FLUSH=0, the next edge SHALL load the decoded control and set OUT_VALID=1, giving a latency of 1 cycle.
REQ-009 In RUN with IN_VALID=0, the next edge SHALL load NOP control (all outputs 0).
REQ-010 Decode encodings:
- ALUOP: ADD/ADDI/load/AUIPC=00001, AND=00010, OR=00011, XOR=00100, SLL=00101, SRL=00110, SRA=00111, SUB/BEQ/BNE=01000.
- ALUOP: MUL=01001, MULH=01010, MULHU=01011, MULHSU=01100, DIV=01101, DIVU=01110, REM=01111, REMU=10000.
- ALUOP: SLT/BLT/BGE=10001, SLTU/BLTU/BGEU=10010, store/LUI=00000.
REQ-011 LOADSIGNAL SHALL be LB=1, LH=2, LW=3, LBU=4, LHU=5, LUI/AUIPC=6.
REQ-012 STORESIGNAL SHALL be SB=1, SH=2, SW=3.
REQ-013 BRANCHSIGNAL SHALL be BEQ=1, BNE=2, BLT=3, BGE=4, BLTU=5, BGEU=6.
REQ-014 IMMflag SHALL be 1 for OP-IMM, LUI and AUIPC.
REQ-015 SELECTWRITE SHALL be 1 for loads.
REQ-016 Jumpflag SHALL be 1 for JAL and JALR.
REQ-017 WRITEENABLE SHALL be 1 for OP, OP-IMM, load, LUI, AUIPC, JAL and JALR, and 0 for store and branch.
REQ-018 An unlisted opcode, func3 or func7 combination SHALL load NOP control with ILLEGAL=1 and OUT_VALID=1 for exactly one cycle.
REQ-019 A load or store SHALL set READ or WRITE with OUT_VALID and enter MEM.
REQ-020 In MEM, READ/WRITE and all control SHALL hold until BUSYWAIT is sampled 0 at an edge no earlier than the first edge after entry.
REQ-021 At that edge READ/WRITE SHALL clear, OUT_VALID SHALL drop for the cycle, and the FSM SHALL return to RUN.
REQ-022 An M instruction with latency L>1 SHALL enter MDIV and load an internal counter with L-1.
REQ-023 In MDIV the counter SHALL decrement each cycle; control SHALL hold; the FSM SHALL return to RUN when the counter reaches 0.
REQ-024 An M instruction with L=1 SHALL stay in RUN.
REQ-025 DECODE_STALL SHALL be 1 exactly while the FSM is in MEM or MDIV; ID inputs are ignored while it is 1.
REQ-026 FLUSH in RUN or MDIV SHALL, at the next edge, load NOP control, set OUT_VALID=0 and go to RUN; FLUSH has priority over IN_VALID.
REQ-027 FLUSH in MEM SHALL clear WRITEENABLE and SELECTWRITE only; READ/WRITE SHALL complete the handshake before RUN.
REQ-028 FLUSH together with BUSYWAIT=0 in MEM SHALL go straight to RUN with NOP control.

Reset
REQ-029 RESET=1 SHALL immediately force state RUN, counter 0, and every output 0, independent of CLK.
REQ-030 RESET asserted mid-MEM or mid-MDIV SHALL abandon the operation; after release, the first edge SHALL decode normally.

Verification
REQ-031 ADD x3,x1,x2 (0x002081B3), IN_VALID=1 -> next edge: ALUOP=00001, WRITEENABLE=1, OUT_VALID=1, DECODE_STALL=0.
REQ-032 LW (0x0000A183), BUSYWAIT high for 3 cycles -> READ=1, SELECTWRITE=1, LOADSIGNAL=3, DECODE_STALL=1 for 3 cycles; the edge after BUSYWAIT falls clears READ.
REQ-033 DIV (0x0220C1B3) with DIV_LAT=4 -> ALUOP=01101, DECODE_STALL=1 for 3 cycles, then RUN; with ENABLE_M=0 -> ILLEGAL=1 for one cycle.
REQ-034 SW with FLUSH in the second MEM cycle -> WRITE stays 1 until BUSYWAIT=0, WRITEENABLE=0, then NOP.
REQ-035 RESET pulsed during MDIV cycle 2 -> all outputs 0 asynchronously; a BEQ (0x00208063) after release -> BRANCHSIGNAL=1, ALUOP=01000, WRITEENABLE=0.

Source files
------------

// File: rtl/rv32im_ctrl_pipe.sv
// rv32im_ctrl_pipe
//   Registered RV32IM control decoder with a small run/memory/multi-cycle FSM.
//   The instruction in ID is decoded and the resulting control word is loaded
//   into output flops on the next rising edge. Loads/stores hold the control word
//   until the data memory releases BUSYWAIT. Multi-cycle M-extension operations
//   hold it for their configured latency. ID is stalled while either is in progress.
//
// Ports
//   CLK, RESET            rising-edge clock, asynchronous active-high reset
//   INSTRUCTION, IN_VALID instruction word in ID and its valid
//   FLUSH                 kill the ID instruction and the registered control
//   BUSYWAIT              data memory busy
//   OUT_VALID             registered control word is valid
//   DECODE_STALL          ID must hold INSTRUCTION (FSM in MEM or MDIV)
//   ALUOP .. STORESIGNAL  registered control fields
module rv32im_ctrl_pipe #(
    parameter int ALUOP_W  = 5,
    parameter int ENABLE_M = 1,
    parameter int MUL_LAT  = 1,
    parameter int DIV_LAT  = 4
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [31:0]        INSTRUCTION,
    input  logic               IN_VALID,
    input  logic               FLUSH,
    input  logic               BUSYWAIT,
    output logic               OUT_VALID,
    output logic               DECODE_STALL,
    output logic [ALUOP_W-1:0] ALUOP,
    output logic               IMMflag,
    output logic               Jumpflag,
    output logic               SELECTWRITE,
    output logic               WRITEENABLE,
    output logic               READ,
    output logic               WRITE,
    output logic               ILLEGAL,
    output logic [2:0]         LOADSIGNAL,
    output logic [2:0]         BRANCHSIGNAL,
    output logic [1:0]         STORESIGNAL
);

    localparam logic [1:0] StRun  = 2'd0;
    localparam logic [1:0] StMem  = 2'd1;
    localparam logic [1:0] StMdiv = 2'd2;

    localparam logic [6:0] OpOp     = 7'b0110011;
    localparam logic [6:0] OpOpImm  = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    localparam logic [6:0] F7Base = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;
    localparam logic [6:0] F7Mext = 7'b0000001;

    localparam logic [4:0] AluNone = 5'b00000;
    localparam logic [4:0] AluAdd  = 5'b00001;
    localparam logic [4:0] AluAnd  = 5'b00010;
    localparam logic [4:0] AluOr   = 5'b00011;
    localparam logic [4:0] AluXor  = 5'b00100;
    localparam logic [4:0] AluSll  = 5'b00101;
    localparam logic [4:0] AluSrl  = 5'b00110;
    localparam logic [4:0] AluSra  = 5'b00111;
    localparam logic [4:0] AluSub  = 5'b01000;
    localparam logic [4:0] AluSlt  = 5'b10001;
    localparam logic [4:0] AluSltu = 5'b10010;

    // Counter wide enough for DIV_LAT up to 33.
    localparam int CNT_W = 6;

    typedef struct packed {
        logic               valid;
        logic [ALUOP_W-1:0] aluop;
        logic               imm;
        logic               jump;
        logic               selw;
        logic               we;
        logic               rd;
        logic               wr;
        logic               ill;
        logic [2:0]         ld;
        logic [2:0]         br;
        logic [1:0]         st;
    } ctrl_t;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_t            ctrl_q, ctrl_d;

    ctrl_t            dec;
    logic             dec_ill;
    logic             dec_mem;
    logic [CNT_W-1:0] dec_lat;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opcode = INSTRUCTION[6:0];
    assign f3     = INSTRUCTION[14:12];
    assign f7     = INSTRUCTION[31:25];

    // Register and immediate fields are not needed for control decode.
    logic unused_fields;
    assign unused_fields = ^{INSTRUCTION[24:15], INSTRUCTION[11:7]};

    // Pure decode of the ID instruction.
    always_comb begin
        dec     = '0;
        dec_ill = 1'b0;
        dec_mem = 1'b0;
        dec_lat = CNT_W'(1);
        case (opcode)
            OpOp: begin
                dec.we = 1'b1;
                if (f7 == F7Base) begin
                    case (f3)
                        3'b000:  dec.aluop = ALUOP_W'(AluAdd);
                        3'b001:  dec.aluop = ALUOP_W'(AluSll);
                        3'b010:  dec.aluop = ALUOP_W'(AluSlt);
                        3'b011:  dec.aluop = ALUOP_W'(AluSltu);
                        3'b100:  dec.aluop = ALUOP_W'(AluXor);
                        3'b101:  dec.aluop = ALUOP_W'(AluSrl);
                        3'b110:  dec.aluop = ALUOP_W'(AluOr);
                        default: dec.aluop = ALUOP_W'(AluAnd);
                    endcase
                end else if (f7 == F7Alt && f3 == 3'b000) begin
                    dec.aluop = ALUOP_W'(AluSub);
                end else if (f7 == F7Alt && f3 == 3'b101) begin
                    dec.aluop = ALUOP_W'(AluSra);
                end else if (f7 == F7Mext && ENABLE_M != 0) begin
                    case (f3)
                        3'b000:  dec.aluop = ALUOP_W'(5'b01001);
                        3'b001:  dec.aluop = ALUOP_W'(5'b01010);
                        3'b010:  dec.aluop = ALUOP_W'(5'b01100);
                        3'b011:  dec.aluop = ALUOP_W'(5'b01011);
                        3'b100:  dec.aluop = ALUOP_W'(5'b01101);
                        3'b101:  dec.aluop = ALUOP_W'(5'b01110);
                        3'b110:  dec.aluop = ALUOP_W'(5'b01111);
                        default: dec.aluop = ALUOP_W'(5'b10000);
                    endcase
                    // f3[2] separates divide/remainder from multiply.
                    dec_lat = f3[2] ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
                end else begin
                    dec_ill = 1'b1;
                end
            end
            OpOpImm: begin
                dec.imm = 1'b1;
                dec.we  = 1'b1;
                case (f3)
                    3'b000:  dec.aluop = ALUOP_W'(AluAdd);
                    3'b010:  dec.aluop = ALUOP_W'(AluSlt);
                    3'b011:  dec.aluop = ALUOP_W'(AluSltu);
                    3'b100:  dec.aluop = ALUOP_W'(AluXor);
                    3'b110:  dec.aluop = ALUOP_W'(AluOr);
                    3'b111:  dec.aluop = ALUOP_W'(AluAnd);
                    3'b001: begin
                        dec.aluop = ALUOP_W'(AluSll);
                        dec_ill   = (f7 != F7Base);
                    end
                    default: begin
                        dec.aluop = (f7 == F7Alt) ? ALUOP_W'(AluSra) : ALUOP_W'(AluSrl);
                        dec_ill   = (f7 != F7Base) && (f7 != F7Alt);
                    end
                endcase
            end
            OpLoad: begin
                dec.aluop = ALUOP_W'(AluAdd);
                dec.selw  = 1'b1;
                dec.we    = 1'b1;
                dec.rd    = 1'b1;
                dec_mem   = 1'b1;
                case (f3)
                    3'b000:  dec.ld = 3'd1;
                    3'b001:  dec.ld = 3'd2;
                    3'b010:  dec.ld = 3'd3;
                    3'b100:  dec.ld = 3'd4;
                    3'b101:  dec.ld = 3'd5;
                    default: dec_ill = 1'b1;
                endcase
            end
            OpStore: begin
                dec.aluop = ALUOP_W'(AluNone);
                dec.wr    = 1'b1;
                dec_mem   = 1'b1;
                case (f3)
                    3'b000:  dec.st = 2'd1;
                    3'b001:  dec.st = 2'd2;
                    3'b010:  dec.st = 2'd3;
                    default: dec_ill = 1'b1;
                endcase
            end
            OpBranch: begin
                case (f3)
                    3'b000: begin dec.br = 3'd1; dec.aluop = ALUOP_W'(AluSub);  end
                    3'b001: begin dec.br = 3'd2; dec.aluop = ALUOP_W'(AluSub);  end
                    3'b100: begin dec.br = 3'd3; dec.aluop = ALUOP_W'(AluSlt);  end
                    3'b101: begin dec.br = 3'd4; dec.aluop = ALUOP_W'(AluSlt);  end
                    3'b110: begin dec.br = 3'd5; dec.aluop = ALUOP_W'(AluSltu); end
                    3'b111: begin dec.br = 3'd6; dec.aluop = ALUOP_W'(AluSltu); end
                    default: dec_ill = 1'b1;
                endcase
            end
            OpLui: begin
                dec.aluop = ALUOP_W'(AluNone);
                dec.imm   = 1'b1;
                dec.we    = 1'b1;
                dec.ld    = 3'd6;
            end
            OpAuipc: begin
                dec.aluop = ALUOP_W'(AluAdd);
                dec.imm   = 1'b1;
                dec.we    = 1'b1;
                dec.ld    = 3'd6;
            end
            OpJal: begin
                dec.jump = 1'b1;
                dec.we   = 1'b1;
            end
            OpJalr: begin
                dec.jump = 1'b1;
                dec.we   = 1'b1;
                dec_ill  = (f3 != 3'b000);
            end
            default: dec_ill = 1'b1;
        endcase

        // Illegal encodings present as a valid NOP tagged ILLEGAL.
        if (dec_ill) begin
            dec     = '0;
            dec.ill = 1'b1;
            dec_mem = 1'b0;
            dec_lat = CNT_W'(1);
        end
        dec.valid = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl_d  = ctrl_q;
        case (state_q)
            StRun: begin
                if (FLUSH || !IN_VALID) begin
                    ctrl_d = '0;
                end else begin
                    ctrl_d = dec;
                    if (dec_mem) begin
                        state_d = StMem;
                    end else if (dec_lat > CNT_W'(1)) begin
                        state_d = StMdiv;
                        cnt_d   = dec_lat - CNT_W'(1);
                    end
                end
            end
            StMem: begin
                if (!BUSYWAIT) begin
                    ctrl_d  = '0;
                    state_d = StRun;
                end else if (FLUSH) begin
                    // The memory handshake must finish; only suppress writeback.
                    ctrl_d.we   = 1'b0;
                    ctrl_d.selw = 1'b0;
                end
            end
            StMdiv: begin
                if (FLUSH) begin
                    ctrl_d  = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end else if (cnt_q <= CNT_W'(1)) begin
                    // Last EX cycle: control stays up, ID is released.
                    cnt_d   = '0;
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                ctrl_d  = '0;
                cnt_d   = '0;
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StRun;
            cnt_q   <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign OUT_VALID    = ctrl_q.valid;
    assign DECODE_STALL = (state_q != StRun);
    assign ALUOP        = ctrl_q.aluop;
    assign IMMflag      = ctrl_q.imm;
    assign Jumpflag     = ctrl_q.jump;
    assign SELECTWRITE  = ctrl_q.selw;
    assign WRITEENABLE  = ctrl_q.we;
    assign READ         = ctrl_q.rd;
    assign WRITE        = ctrl_q.wr;
    assign ILLEGAL      = ctrl_q.ill;
    assign LOADSIGNAL   = ctrl_q.ld;
    assign BRANCHSIGNAL = ctrl_q.br;
    assign STORESIGNAL  = ctrl_q.st;

endmodule

// File: tb/tb_rv32im_ctrl_pipe.sv
// Directed bench for rv32im_ctrl_pipe. A default instance (ENABLE_M=1, MUL_LAT=1,
// DIV_LAT=4) is checked on every output. A second instance with ENABLE_M=0 shares
// the stimulus and has its ILLEGAL output checked as well.
module tb_rv32im_ctrl_pipe;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] INSTRUCTION;
    logic        IN_VALID;
    logic        FLUSH;
    logic        BUSYWAIT;

    logic       out_valid, decode_stall, immflag, jumpflag, selectwrite, writeenable;
    logic       read_o, write_o, illegal;
    logic [4:0] aluop;
    logic [2:0] loadsignal, branchsignal;
    logic [1:0] storesignal;

    logic       n_out_valid, n_decode_stall, n_immflag, n_jumpflag, n_selectwrite;
    logic       n_writeenable, n_read, n_write, n_illegal;
    logic [4:0] n_aluop;
    logic [2:0] n_loadsignal, n_branchsignal;
    logic [1:0] n_storesignal;

    rv32im_ctrl_pipe dut (
        .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .IN_VALID(IN_VALID),
        .FLUSH(FLUSH), .BUSYWAIT(BUSYWAIT), .OUT_VALID(out_valid),
        .DECODE_STALL(decode_stall), .ALUOP(aluop), .IMMflag(immflag),
        .Jumpflag(jumpflag), .SELECTWRITE(selectwrite), .WRITEENABLE(writeenable),
        .READ(read_o), .WRITE(write_o), .ILLEGAL(illegal), .LOADSIGNAL(loadsignal),
        .BRANCHSIGNAL(branchsignal), .STORESIGNAL(storesignal)
    );

    rv32im_ctrl_pipe #(.ENABLE_M(0)) dut_nom (
        .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .IN_VALID(IN_VALID),
        .FLUSH(FLUSH), .BUSYWAIT(BUSYWAIT), .OUT_VALID(n_out_valid),
        .DECODE_STALL(n_decode_stall), .ALUOP(n_aluop), .IMMflag(n_immflag),
        .Jumpflag(n_jumpflag), .SELECTWRITE(n_selectwrite), .WRITEENABLE(n_writeenable),
        .READ(n_read), .WRITE(n_write), .ILLEGAL(n_illegal), .LOADSIGNAL(n_loadsignal),
        .BRANCHSIGNAL(n_branchsignal), .STORESIGNAL(n_storesignal)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    typedef struct {
        string       tag;
        logic [21:0] exp;
        logic        nom_ill;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    logic [21:0] obs;
    assign obs = {out_valid, decode_stall, aluop, immflag, jumpflag, selectwrite,
                  writeenable, read_o, write_o, illegal, loadsignal, branchsignal,
                  storesignal};

    // Field order: valid, stall, aluop, imm, jump, selw, we, read, write, ill, ld, br, st.
    function automatic logic [21:0] mk(input logic v, input logic stl, input logic [4:0] alu,
                                       input logic imm, input logic jmp, input logic selw,
                                       input logic we, input logic rd, input logic wr,
                                       input logic ill, input logic [2:0] ld,
                                       input logic [2:0] br, input logic [1:0] st);
        return {v, stl, alu, imm, jmp, selw, we, rd, wr, ill, ld, br, st};
    endfunction

    task automatic drive(input logic [31:0] instr, input logic v, input logic fl,
                         input logic bw);
        INSTRUCTION = instr;
        IN_VALID    = v;
        FLUSH       = fl;
        BUSYWAIT    = bw;
    endtask

    task automatic compare_front();
        exp_t e;
        e = sb.pop_front();
        total = total + 1;
        assert (obs === e.exp) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
        total = total + 1;
        assert (n_illegal === e.nom_ill) passed = passed + 1;
        else $error("FAIL %s_nom_ill: observed %b expected %b", e.tag, n_illegal, e.nom_ill);
    endtask

    // Push the expectation for the next edge, then compare just after it.
    task automatic cycle(input string tag, input logic [21:0] exp, input logic nom_ill);
        exp_t e;
        e.tag     = tag;
        e.exp     = exp;
        e.nom_ill = nom_ill;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        compare_front();
    endtask

    // Compare immediately without waiting for a clock edge.
    task automatic now(input string tag, input logic [21:0] exp, input logic nom_ill);
        exp_t e;
        e.tag     = tag;
        e.exp     = exp;
        e.nom_ill = nom_ill;
        sb.push_back(e);
        compare_front();
    endtask

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_ADDI = 32'h00508193;
    localparam logic [31:0] I_SRAI = 32'h4020D193;
    localparam logic [31:0] I_LUI  = 32'h123451B7;
    localparam logic [31:0] I_JAL  = 32'h008000EF;
    localparam logic [31:0] I_BLTU = 32'h0020E063;
    localparam logic [31:0] I_BEQ  = 32'h00208063;
    localparam logic [31:0] I_MUL  = 32'h022081B3;
    localparam logic [31:0] I_DIV  = 32'h0220C1B3;
    localparam logic [31:0] I_REMU = 32'h0220F1B3;
    localparam logic [31:0] I_LW   = 32'h0000A183;
    localparam logic [31:0] I_LBU  = 32'h0000C183;
    localparam logic [31:0] I_SW   = 32'h0020A023;
    localparam logic [31:0] I_BAD  = 32'h00000000;

    initial begin
        logic [21:0] nop, e_add, e_lw, e_lw_fl, e_lbu, e_sw, e_div, e_div_end, e_remu;
        nop       = '0;
        e_add     = mk(1, 0, 5'b00001, 0, 0, 0, 1, 0, 0, 0, 3'd0, 3'd0, 2'd0);
        e_lw      = mk(1, 1, 5'b00001, 0, 0, 1, 1, 1, 0, 0, 3'd3, 3'd0, 2'd0);
        e_lw_fl   = mk(1, 1, 5'b00001, 0, 0, 0, 0, 1, 0, 0, 3'd3, 3'd0, 2'd0);
        e_lbu     = mk(1, 1, 5'b00001, 0, 0, 1, 1, 1, 0, 0, 3'd4, 3'd0, 2'd0);
        e_sw      = mk(1, 1, 5'b00000, 0, 0, 0, 0, 0, 1, 0, 3'd0, 3'd0, 2'd3);
        e_div     = mk(1, 1, 5'b01101, 0, 0, 0, 1, 0, 0, 0, 3'd0, 3'd0, 2'd0);
        e_div_end = mk(1, 0, 5'b01101, 0, 0, 0, 1, 0, 0, 0, 3'd0, 3'd0, 2'd0);
        e_remu    = mk(1, 1, 5'b10000, 0, 0, 0, 1, 0, 0, 0, 3'd0, 3'd0, 2'd0);

        RESET = 1'b1;
        drive(I_ADD, 1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge CLK);
        #1;
        now("reset_hold", nop, 1'b0);
        RESET = 1'b0;

        drive(I_ADD, 1'b0, 1'b0, 1'b0); cycle("idle_nop", nop, 1'b0);
        drive(I_ADD, 1'b1, 1'b0, 1'b0); cycle("add", e_add, 1'b0);
        drive(I_SUB, 1'b1, 1'b0, 1'b0);
        cycle("sub", mk(1, 0, 5'b01000, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1'b0);
        drive(I_ADDI, 1'b1, 1'b0, 1'b0);
        cycle("addi", mk(1, 0, 5'b00001, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1'b0);
        drive(I_SRAI, 1'b1, 1'b0, 1'b0);
        cycle("srai", mk(1, 0, 5'b00111, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1'b0);
        drive(I_LUI, 1'b1, 1'b0, 1'b0);
        cycle("lui", mk(1, 0, 5'b00000, 1, 0, 0, 1, 0, 0, 0, 3'd6, 0, 0), 1'b0);
        drive(I_JAL, 1'b1, 1'b0, 1'b0);
        cycle("jal", mk(1, 0, 5'b00000, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0), 1'b0);
        drive(I_BLTU, 1'b1, 1'b0, 1'b0);
        cycle("bltu", mk(1, 0, 5'b10010, 0, 0, 0, 0, 0, 0, 0, 0, 3'd5, 0), 1'b0);
        drive(I_BAD, 1'b1, 1'b0, 1'b0);
        cycle("illegal", mk(1, 0, 5'b00000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 1'b1);
        drive(I_ADD, 1'b1, 1'b1, 1'b0); cycle("flush_over_valid", nop, 1'b0);
        drive(I_MUL, 1'b1, 1'b0, 1'b0);
        cycle("mul_lat1", mk(1, 0, 5'b01001, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1'b1);

        // Load with BUSYWAIT high for three sampled edges.
        drive(I_LW, 1'b1, 1'b0, 1'b1);  cycle("lw_enter", e_lw, 1'b0);
        drive(I_ADD, 1'b1, 1'b0, 1'b1); cycle("lw_hold1", e_lw, 1'b0);
        drive(I_ADD, 1'b1, 1'b0, 1'b1); cycle("lw_hold2", e_lw, 1'b0);
        drive(I_ADD, 1'b1, 1'b0, 1'b0); cycle("lw_done", nop, 1'b0);

        // BUSYWAIT already low: MEM still lasts one cycle.
        drive(I_LBU, 1'b1, 1'b0, 1'b0); cycle("lbu_enter", e_lbu, 1'b0);
        drive(I_ADD, 1'b1, 1'b0, 1'b0); cycle("lbu_done", nop, 1'b0);

        // Store flushed in its second MEM cycle keeps WRITE until BUSYWAIT drops.
        drive(I_SW, 1'b1, 1'b0, 1'b1);  cycle("sw_enter", e_sw, 1'b0);
        drive(I_ADD, 1'b1, 1'b1, 1'b1); cycle("sw_flush", e_sw, 1'b0);
        drive(I_ADD, 1'b1, 1'b0, 1'b1); cycle("sw_hold", e_sw, 1'b0);
        drive(I_ADD, 1'b1, 1'b0, 1'b0); cycle("sw_done", nop, 1'b0);

        // Flushed load drops writeback only; flush with BUSYWAIT low ends it.
        drive(I_LW, 1'b1, 1'b0, 1'b1);  cycle("lw2_enter", e_lw, 1'b0);
        drive(I_ADD, 1'b1, 1'b1, 1'b1); cycle("lw2_flush", e_lw_fl, 1'b0);
        drive(I_ADD, 1'b1, 1'b0, 1'b1); cycle("lw2_hold", e_lw_fl, 1'b0);
        drive(I_ADD, 1'b1, 1'b1, 1'b0); cycle("lw2_flush_done", nop, 1'b0);

        // DIV: three stall cycles, control held for four.
        drive(I_DIV, 1'b1, 1'b0, 1'b0); cycle("div_enter", e_div, 1'b1);
        drive(I_ADD, 1'b1, 1'b0, 1'b0); cycle("div_c1", e_div, 1'b0);
        drive(I_ADD, 1'b0, 1'b0, 1'b0); cycle("div_c2", e_div, 1'b0);
        drive(I_ADD, 1'b0, 1'b0, 1'b0); cycle("div_last", e_div_end, 1'b0);
        drive(I_ADD, 1'b0, 1'b0, 1'b0); cycle("div_after", nop, 1'b0);

        drive(I_REMU, 1'b1, 1'b0, 1'b0); cycle("remu_enter", e_remu, 1'b1);
        drive(I_ADD, 1'b1, 1'b1, 1'b0);  cycle("remu_flush", nop, 1'b0);

        // Asynchronous reset in MDIV cycle 2.
        drive(I_DIV, 1'b1, 1'b0, 1'b0); cycle("div2_enter", e_div, 1'b1);
        drive(I_ADD, 1'b0, 1'b0, 1'b0); cycle("div2_c1", e_div, 1'b0);
        RESET = 1'b1;
        #2;
        now("async_reset", nop, 1'b0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        drive(I_BEQ, 1'b1, 1'b0, 1'b0);
        cycle("beq_after_reset", mk(1, 0, 5'b01000, 0, 0, 0, 0, 0, 0, 0, 0, 3'd1, 0), 1'b0);
        drive(I_ADD, 1'b0, 1'b0, 1'b0); cycle("final_idle", nop, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
